// File: rtl/c432_hd_monitor.sv
// rtl/c432_hd_monitor.sv - Hamming-distance switching-activity monitor for c432 outputs
//
// Captures the c432 primary-output vector on each sample strobe. Over a window of
// WIN_LEN transitions it accumulates a saturating HD sum, the peak single HD and a
// sticky per-bit toggle mask. The summary is then offered through a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             one-cycle pulse that opens a window; honoured only in IDLE
//   sample_vld/dat    captured output vector {N432,N431,N430,N421,N370,N329,N223}
//   busy              window in progress (PRIME or ACCUM)
//   res_vld/res_rdy   result handshake
//   res_hd_sum        saturating sum of HD over the window
//   res_max_hd        largest single HD in the window
//   res_tog_mask      bit i set if output bit i toggled during the window
module c432_hd_monitor #(
    parameter int OUT_W   = 7,
    parameter int WIN_LEN = 16,
    parameter int ACC_W   = 16,
    localparam int HD_W   = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_vld,
    input  logic [OUT_W-1:0] sample_dat,
    output logic             busy,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [ACC_W-1:0] res_hd_sum,
    output logic [HD_W-1:0]  res_max_hd,
    output logic [OUT_W-1:0] res_tog_mask
);

    localparam int CNT_W = $clog2(WIN_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   prev_q, prev_d;
    logic [OUT_W-1:0]   mask_q, mask_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [HD_W-1:0]    max_q, max_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [OUT_W-1:0]   diff;
    logic [HD_W-1:0]    hd;
    logic [ACC_W:0]     sum_ext;

    // Popcount and the one-bit-wider add feeding saturation, all in one cycle.
    always_comb begin
        diff = sample_dat ^ prev_q;
        hd   = '0;
        for (int i = 0; i < OUT_W; i++) begin
            hd = hd + HD_W'(diff[i]);
        end
        sum_ext = {1'b0, sum_q} + (ACC_W + 1)'(hd);
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        mask_d  = mask_q;
        sum_d   = sum_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                // A coincident sample is dropped; the baseline comes from PRIME.
                if (start) begin
                    state_d = S_PRIME;
                    mask_d  = '0;
                    sum_d   = '0;
                    max_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_PRIME: begin
                if (sample_vld) begin
                    prev_d  = sample_dat;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (sample_vld) begin
                    prev_d = sample_dat;
                    mask_d = mask_q | diff;
                    sum_d  = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
                    max_d  = (hd > max_q) ? hd : max_q;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIN_LEN - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (res_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            prev_q  <= '0;
            mask_q  <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            mask_q  <= mask_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from flops; results hold until the next accepted start.
    assign busy         = (state_q == S_PRIME) || (state_q == S_ACCUM);
    assign res_vld      = (state_q == S_DONE);
    assign res_hd_sum   = sum_q;
    assign res_max_hd   = max_q;
    assign res_tog_mask = mask_q;

endmodule

// File: tb/tb_c432_hd_monitor.sv
// tb/tb_c432_hd_monitor.sv - table-driven and randomized bench for c432_hd_monitor
module tb_c432_hd_monitor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sample_vld;
    logic [6:0]  sample_dat;
    logic        res_rdy;

    logic        d_busy, d_vld;
    logic [15:0] d_sum;
    logic [2:0]  d_max;
    logic [6:0]  d_mask;
    logic        s_busy, s_vld;
    logic [3:0]  s_sum;
    logic [2:0]  s_max;
    logic [6:0]  s_mask;

    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;

    c432_hd_monitor #(.OUT_W(7), .WIN_LEN(4), .ACC_W(16)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_vld(sample_vld),
        .sample_dat(sample_dat), .busy(d_busy), .res_vld(d_vld), .res_rdy(res_rdy),
        .res_hd_sum(d_sum), .res_max_hd(d_max), .res_tog_mask(d_mask)
    );

    c432_hd_monitor #(.OUT_W(7), .WIN_LEN(4), .ACC_W(4)) u_s (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_vld(sample_vld),
        .sample_dat(sample_dat), .busy(s_busy), .res_vld(s_vld), .res_rdy(res_rdy),
        .res_hd_sum(s_sum), .res_max_hd(s_max), .res_tog_mask(s_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [34:0] smp;
        int          maxgap;
        int          rdy_wait;
        bit          noise;
        int          e_sum;
        int          e_sum4;
        int          e_max;
        int          e_mask;
    } vec_t;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d expected=%0d", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (d_busy) busy_cnt++;
    endtask

    function automatic logic [34:0] pack5(input logic [6:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    // Reference: HD is the popcount of the XOR of neighbouring samples; the 4-bit
    // accumulator result is the true total clipped at 15.
    function automatic void ref_model(input logic [34:0] smp, output int sum,
                                      output int sum4, output int mx, output int mask);
        logic [6:0] a, b, d;
        int h;
        sum = 0; mx = 0; mask = 0;
        for (int k = 1; k < 5; k++) begin
            a = smp[7*(k-1) +: 7];
            b = smp[7*k +: 7];
            d = a ^ b;
            h = $countones(d);
            sum += h;
            if (h > mx) mx = h;
            mask |= int'(d);
        end
        sum4 = (sum > 15) ? 15 : sum;
    endfunction

    task automatic run_window(input logic [34:0] smp, input int maxgap, input int rdy_wait,
                              input bit noise, input int idx, input int e_sum, input int e_sum4,
                              input int e_max, input int e_mask);
        int  gaps;
        int  g;
        bit  stable_ok;
        bit  idle_ok;
        int  o_sum, o_sum4, o_max, o_mask;
        gaps = 0;
        stable_ok = 1'b1;
        busy_cnt = 0;
        if (noise) begin
            sample_vld = 1'b1;
            sample_dat = 7'($urandom);
            step();
        end
        start = 1'b1;
        sample_vld = noise;
        sample_dat = 7'($urandom);
        step();
        start = 1'b0;
        sample_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            gaps += g;
            for (int j = 0; j < g; j++) begin
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                sample_dat = 7'($urandom);
                step();
                start = 1'b0;
            end
            sample_vld = 1'b1;
            sample_dat = smp[7*k +: 7];
            step();
            sample_vld = 1'b0;
        end
        chk("res_vld_latency", idx, int'(d_vld && s_vld && !d_busy && !s_busy), 1);
        chk("busy_cycles", idx, busy_cnt, 5 + gaps);
        chk("hd_sum", idx, int'(d_sum), e_sum);
        chk("hd_sum_sat", idx, int'(s_sum), e_sum4);
        chk("max_hd", idx, int'(d_max), e_max);
        chk("max_hd_sat", idx, int'(s_max), e_max);
        chk("tog_mask", idx, int'(d_mask), e_mask);
        chk("tog_mask_sat", idx, int'(s_mask), e_mask);
        o_sum = int'(d_sum); o_sum4 = int'(s_sum); o_max = int'(d_max); o_mask = int'(d_mask);
        for (int i = 0; i < rdy_wait; i++) begin
            res_rdy = 1'b0;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            sample_vld = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            sample_dat = 7'($urandom);
            step();
            if (!d_vld || !s_vld || int'(d_sum) != o_sum || int'(s_sum) != o_sum4 ||
                int'(d_max) != o_max || int'(d_mask) != o_mask || d_busy)
                stable_ok = 1'b0;
        end
        start = 1'b0;
        sample_vld = 1'b0;
        chk("stall_stable", idx, int'(stable_ok), 1);
        res_rdy = 1'b1;
        start = noise;
        step();
        res_rdy = 1'b0;
        start = 1'b0;
        idle_ok = !d_vld && !s_vld && !d_busy && int'(d_sum) == o_sum && int'(d_mask) == o_mask;
        step();
        idle_ok = idle_ok && !d_vld && !d_busy && int'(d_sum) == o_sum && int'(d_max) == o_max;
        chk("post_handshake_idle", idx, int'(idle_ok), 1);
    endtask

    vec_t tbl [6];

    initial begin
        bit saw_activity;
        int e_sum, e_sum4, e_max, e_mask;
        logic [63:0] r;
        logic [34:0] smp;

        rst_n = 1'b0;
        start = 1'b0;
        sample_vld = 1'b0;
        sample_dat = '0;
        res_rdy = 1'b0;

        tbl[0] = '{pack5(7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00), 0, 0, 1'b0, 28, 15, 7, 'h7F};
        tbl[1] = '{pack5(7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'h2A), 3, 0, 1'b0, 0, 0, 0, 'h00};
        tbl[2] = '{pack5(7'h01, 7'h02, 7'h04, 7'h08, 7'h10), 0, 10, 1'b1, 8, 8, 2, 'h1F};
        tbl[3] = '{pack5(7'h00, 7'h01, 7'h03, 7'h07, 7'h0F), 2, 2, 1'b0, 4, 4, 1, 'h0F};
        tbl[4] = '{pack5(7'h40, 7'h41, 7'h40, 7'h00, 7'h7F), 1, 10, 1'b1, 10, 10, 7, 'h7F};
        tbl[5] = '{pack5(7'h7F, 7'h7E, 7'h7C, 7'h78, 7'h70), 0, 0, 1'b0, 4, 4, 1, 'h0F};

        // Reset held with inputs toggling.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            start = ~start;
            sample_vld = ~sample_vld;
            sample_dat = 7'($urandom);
        end
        chk("reset_outputs_d", 0, int'({d_busy, d_vld, d_sum, d_max, d_mask}), 0);
        chk("reset_outputs_s", 0, int'({s_busy, s_vld, s_sum, s_max, s_mask}), 0);
        start = 1'b0;
        rst_n = 1'b1;
        saw_activity = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample_vld = 1'($urandom_range(0, 1));
            sample_dat = 7'($urandom);
            step();
            if (d_vld || d_busy || s_vld || s_busy) saw_activity = 1'b1;
        end
        sample_vld = 1'b0;
        chk("idle_without_start", 0, int'(saw_activity), 0);

        // Table-driven windows.
        for (int i = 0; i < 6; i++) begin
            run_window(tbl[i].smp, tbl[i].maxgap, tbl[i].rdy_wait, tbl[i].noise, i,
                       tbl[i].e_sum, tbl[i].e_sum4, tbl[i].e_max, tbl[i].e_mask);
        end

        // Mid-window reset: baseline 0x01, then 0x03 and 0x00 accumulated.
        start = 1'b1;
        step();
        start = 1'b0;
        sample_vld = 1'b1;
        sample_dat = 7'h01; step();
        sample_dat = 7'h03; step();
        sample_dat = 7'h00; step();
        sample_vld = 1'b0;
        chk("mid_window_partial_sum", 0, int'(d_sum), 3);
        chk("mid_window_busy", 0, int'(d_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs_d", 0, int'({d_busy, d_vld, d_sum, d_max, d_mask}), 0);
        chk("async_reset_outputs_s", 0, int'({s_busy, s_vld, s_sum, s_max, s_mask}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        run_window(pack5(7'h01, 7'h02, 7'h04, 7'h08, 7'h10), 0, 0, 1'b0, 100, 8, 8, 2, 'h1F);

        // Randomized windows against the reference model.
        for (int n = 0; n < 30; n++) begin
            r = {$urandom(), $urandom()};
            smp = r[34:0];
            if (n % 7 == 3) smp = {5{smp[6:0]}};
            ref_model(smp, e_sum, e_sum4, e_max, e_mask);
            run_window(smp, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                       1'($urandom_range(0, 1)), 200 + n, e_sum, e_sum4, e_max, e_mask);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
